// File: rtl/trace_pkg.sv
// Shared definitions for the execute-stage debug trace.
//
// trace_rec_t is the packed record layout produced by exec_trace_buf and
// consumed by the debug unit. The *_LSB / *_BIT localparams give the same
// layout as flat bit offsets for code that works on raw vectors.
package trace_pkg;

    localparam int TRACE_REC_W = 204;

    localparam int PC_LSB     = 0;
    localparam int RESULT_LSB = 64;
    localparam int BJ_PC_LSB  = 128;
    localparam int RD_LSB     = 192;
    localparam int BJ_EN_BIT  = 197;
    localparam int CAUSE_LSB  = 198;
    localparam int WFI_BIT    = 203;

    // Field order is MSB first, so pc lands in bits [63:0].
    typedef struct packed {
        logic        wfi_op;
        logic [4:0]  cause;
        logic        bj_en;
        logic [4:0]  rd;
        logic [63:0] bj_pc;
        logic [63:0] result;
        logic [63:0] pc;
    } trace_rec_t;

endpackage

// File: rtl/trace_ring.sv
// Circular record store with separate occupancy count.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush of pointers and count
//   push         write wr_data at wr_ptr and advance wr_ptr
//   pop          advance rd_ptr (drop the head)
//   wr_data      record to store
//   rd_data      combinational read of the head entry
//   count        number of occupied entries, 0..DEPTH
//
// The caller guarantees push is never issued while full unless pop is also
// issued in the same cycle, and pop is never issued while empty. An overwrite
// is expressed as push+pop together, which keeps count constant.
module trace_ring #(
    parameter int DEPTH = 16,
    parameter int W     = 204
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;

    // Occupancy follows push and pop independently; both in one cycle cancel.
    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_nxt;
        end
    end

    // Storage is deliberately not reset; only the pointers give it meaning.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_q;

endmodule

// File: rtl/exec_trace_buf.sv
// Capture side of the execute-stage debug trace.
//
// Records one entry per accepted execute-stage instruction into a DEPTH-entry
// ring, drained oldest-first by the debug unit over a valid/ready port.
// Capture freezes two cycles after a WFI is recorded so the tail of the trace
// shows the halt point.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush: empties ring, zeroes drop_cnt, unfreezes
//   arm               capture enable level
//   ex_valid, stall   execute stage qualifiers
//   pc, rd, result, cause, bj_en, bj_pc, wfi_op   record fields
//   rd_valid, rd_data, rd_ready   reader handshake (rd_data is the head record)
//   count             occupied entries
//   drop_cnt          records lost or overwritten, saturating
//   frozen            capture halted after WFI
//
// With OVERWRITE=1 a write into a full ring without a pop evicts the head, so
// rd_data can change while rd_valid is high and rd_ready low. This is accepted
// for a debug-only port.
module exec_trace_buf
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       arm,
    input  logic                       ex_valid,
    input  logic                       stall,
    input  logic [63:0]                pc,
    input  logic [4:0]                 rd,
    input  logic [63:0]                result,
    input  logic [4:0]                 cause,
    input  logic                       bj_en,
    input  logic [63:0]                bj_pc,
    input  logic                       wfi_op,
    output logic                       rd_valid,
    output logic [TRACE_REC_W-1:0]     rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                drop_cnt,
    output logic                       frozen
);

    localparam int   REC_W = TRACE_REC_W;
    localparam int   CW    = $clog2(DEPTH) + 1;
    localparam logic OW_EN = (OVERWRITE != 0);

    logic [REC_W-1:0] wr_rec;
    logic [CW-1:0]    ring_count;
    logic             we;
    logic             pop_req;
    logic             full;
    logic             ring_push;
    logic             ring_pop;
    logic             drop;
    logic             pending;
    logic             halt_q;

    assign we      = arm & ex_valid & ~stall & ~frozen & ~clear;
    assign pop_req = rd_valid & rd_ready & ~clear;
    assign full    = (ring_count == CW'(DEPTH));

    // When full, a pop frees the slot for the new record. Without a pop the
    // record either evicts the head (push+pop on the ring) or is discarded.
    assign ring_push = we & (~full | pop_req | OW_EN);
    assign ring_pop  = pop_req | (we & full & OW_EN);
    assign drop      = we & full & ~pop_req;

    // Pack the record; the branch target is zeroed when no branch is taken.
    always_comb begin
        wr_rec                        = '0;
        wr_rec[PC_LSB +: 64]          = pc;
        wr_rec[RESULT_LSB +: 64]      = result;
        wr_rec[BJ_PC_LSB +: 64]       = bj_en ? bj_pc : 64'h0;
        wr_rec[RD_LSB +: 5]           = rd;
        wr_rec[BJ_EN_BIT]             = bj_en;
        wr_rec[CAUSE_LSB +: 5]        = cause;
        wr_rec[WFI_BIT]               = wfi_op;
    end

    trace_ring #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .push    (ring_push),
        .pop     (ring_pop),
        .wr_data (wr_rec),
        .rd_data (rd_data),
        .count   (ring_count)
    );

    // Lost-record counter, held at all-ones once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (clear) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Two-stage WFI delay: the WFI record plus the next two accepted
    // instructions make it in before frozen blocks further writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            halt_q  <= 1'b0;
            frozen  <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
            halt_q  <= 1'b0;
            frozen  <= 1'b0;
        end else begin
            pending <= we & wfi_op;
            halt_q  <= pending;
            frozen  <= frozen | halt_q;
        end
    end

    assign rd_valid = (ring_count != '0);
    assign count    = ring_count;

endmodule

// File: tb/tb_exec_trace_buf.sv
// Self-checking bench for exec_trace_buf. Two DEPTH=4 instances share all
// inputs: one overwrites when full, the other drops. Expected records are
// queued per instance as stimulus is issued; a monitor per instance pops and
// compares whenever that instance hands a record to the reader.
module tb_exec_trace_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        arm;
    logic        ex_valid;
    logic        stall;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] result;
    logic [4:0]  cause;
    logic        bj_en;
    logic [63:0] bj_pc;
    logic        wfi_op;
    logic        rd_ready;

    logic         ow_rd_valid, nw_rd_valid;
    logic [203:0] ow_rd_data, nw_rd_data;
    logic [2:0]   ow_count, nw_count;
    logic [15:0]  ow_drop, nw_drop;
    logic         ow_frozen, nw_frozen;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [203:0] exp_ow[$];
    logic [203:0] exp_nw[$];

    always #5 clk = ~clk;

    exec_trace_buf #(.DEPTH(4), .OVERWRITE(1)) dut_ow (
        .clk(clk), .rst_n(rst_n), .clear(clear), .arm(arm),
        .ex_valid(ex_valid), .stall(stall), .pc(pc), .rd(rd),
        .result(result), .cause(cause), .bj_en(bj_en), .bj_pc(bj_pc),
        .wfi_op(wfi_op), .rd_valid(ow_rd_valid), .rd_data(ow_rd_data),
        .rd_ready(rd_ready), .count(ow_count), .drop_cnt(ow_drop),
        .frozen(ow_frozen)
    );

    exec_trace_buf #(.DEPTH(4), .OVERWRITE(0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .clear(clear), .arm(arm),
        .ex_valid(ex_valid), .stall(stall), .pc(pc), .rd(rd),
        .result(result), .cause(cause), .bj_en(bj_en), .bj_pc(bj_pc),
        .wfi_op(wfi_op), .rd_valid(nw_rd_valid), .rd_data(nw_rd_data),
        .rd_ready(rd_ready), .count(nw_count), .drop_cnt(nw_drop),
        .frozen(nw_frozen)
    );

    // Expected record built straight from the documented bit layout.
    function automatic logic [203:0] expRec(input logic [63:0] p, input logic [4:0] r,
                                            input logic [63:0] res, input logic bj,
                                            input logic [63:0] bjt, input logic [4:0] c,
                                            input logic w);
        return {w, c, bj, r, (bj ? bjt : 64'h0), res, p};
    endfunction

    function automatic logic [203:0] simpleRec(input logic [63:0] p, input logic w);
        return expRec(p, 5'd5, 64'h1000 + p, 1'b0, 64'h0, 5'd0, w);
    endfunction

    task automatic checkOutput(input string name, input logic [203:0] act, input logic [203:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of execute-stage input, then return the stage to idle.
    task automatic applyStimulus(input logic v, input logic st, input logic [63:0] p,
                                 input logic [4:0] r, input logic [63:0] res,
                                 input logic bj, input logic [63:0] bjt,
                                 input logic [4:0] c, input logic w);
        ex_valid = v;
        stall    = st;
        pc       = p;
        rd       = r;
        result   = res;
        bj_en    = bj;
        bj_pc    = bjt;
        cause    = c;
        wfi_op   = w;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        stall    = 1'b0;
        wfi_op   = 1'b0;
    endtask

    task automatic writeInstr(input logic [63:0] p, input logic w);
        applyStimulus(1'b1, 1'b0, p, 5'd5, 64'h1000 + p, 1'b0, 64'h0, 5'd0, w);
    endtask

    task automatic pushBoth(input logic [203:0] r);
        exp_ow.push_back(r);
        exp_nw.push_back(r);
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic drainAll(input string tag);
        rd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (ow_count == 3'd0 && nw_count == 3'd0) break;
            @(posedge clk);
            #1;
        end
        rd_ready = 1'b0;
        checkOutput({tag, "_ow_drained"}, 204'(ow_count), 204'(0));
        checkOutput({tag, "_nw_drained"}, 204'(nw_count), 204'(0));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ow_count"},  204'(ow_count),    204'(0));
        checkOutput({tag, "_ow_valid"},  204'(ow_rd_valid), 204'(0));
        checkOutput({tag, "_ow_drop"},   204'(ow_drop),     204'(0));
        checkOutput({tag, "_ow_frozen"}, 204'(ow_frozen),   204'(0));
        checkOutput({tag, "_nw_count"},  204'(nw_count),    204'(0));
        checkOutput({tag, "_nw_valid"},  204'(nw_rd_valid), 204'(0));
        checkOutput({tag, "_nw_drop"},   204'(nw_drop),     204'(0));
        checkOutput({tag, "_nw_frozen"}, 204'(nw_frozen),   204'(0));
    endtask

    // Monitors: a pop happens on the next rising edge, so sample on the falling edge.
    always @(negedge clk) begin
        if (rst_n && ow_rd_valid && rd_ready) begin
            if (exp_ow.size() == 0) begin
                n_cmp  = n_cmp + 1;
                n_fail = n_fail + 1;
                $display("[TB] FAIL ow_unexpected_pop: got %0h expected no record", ow_rd_data);
            end else begin
                checkOutput("ow_rd_data", ow_rd_data, exp_ow.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && nw_rd_valid && rd_ready) begin
            if (exp_nw.size() == 0) begin
                n_cmp  = n_cmp + 1;
                n_fail = n_fail + 1;
                $display("[TB] FAIL nw_unexpected_pop: got %0h expected no record", nw_rd_data);
            end else begin
                checkOutput("nw_rd_data", nw_rd_data, exp_nw.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        arm      = 1'b0;
        ex_valid = 1'b0;
        stall    = 1'b0;
        pc       = '0;
        rd       = '0;
        result   = '0;
        cause    = '0;
        bj_en    = 1'b0;
        bj_pc    = '0;
        wfi_op   = 1'b0;
        rd_ready = 1'b0;

        #12;
        checkReset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic ordering, including branch target masking and cause field
        arm = 1'b1;
        pushBoth(expRec(64'h80000000, 5'd5, 64'h11, 1'b0, 64'h0, 5'd0, 1'b0));
        applyStimulus(1'b1, 1'b0, 64'h80000000, 5'd5, 64'h11, 1'b0, 64'h0, 5'd0, 1'b0);
        pushBoth(expRec(64'h80000004, 5'd5, 64'h22, 1'b1, 64'h80001000, 5'd0, 1'b0));
        applyStimulus(1'b1, 1'b0, 64'h80000004, 5'd5, 64'h22, 1'b1, 64'h80001000, 5'd0, 1'b0);
        pushBoth(expRec(64'h80000008, 5'd5, 64'h33, 1'b0, 64'h0, 5'd3, 1'b0));
        applyStimulus(1'b1, 1'b0, 64'h80000008, 5'd5, 64'h33, 1'b0, 64'hDEADBEEF, 5'd3, 1'b0);
        checkOutput("basic_ow_count", 204'(ow_count), 204'(3));
        checkOutput("basic_nw_count", 204'(nw_count), 204'(3));
        checkOutput("basic_ow_valid", 204'(ow_rd_valid), 204'(1));
        drainAll("basic");
        checkOutput("basic_ow_drop", 204'(ow_drop), 204'(0));

        // Stall, invalid and disarmed cycles capture nothing
        applyStimulus(1'b1, 1'b1, 64'h500, 5'd1, 64'h1, 1'b0, 64'h0, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 64'h500, 5'd1, 64'h1, 1'b0, 64'h0, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'h504, 5'd1, 64'h1, 1'b0, 64'h0, 5'd0, 1'b0);
        arm = 1'b0;
        writeInstr(64'h50C, 1'b0);
        arm = 1'b1;
        checkOutput("gate_ow_count0", 204'(ow_count), 204'(0));
        checkOutput("gate_nw_count0", 204'(nw_count), 204'(0));
        pushBoth(simpleRec(64'h508, 1'b0));
        writeInstr(64'h508, 1'b0);
        checkOutput("gate_ow_count1", 204'(ow_count), 204'(1));
        drainAll("gate");

        // Six writes into four slots with no reads
        for (int i = 0; i < 6; i++) begin
            writeInstr(64'(i * 4), 1'b0);
        end
        checkOutput("full_ow_count", 204'(ow_count), 204'(4));
        checkOutput("full_ow_drop",  204'(ow_drop),  204'(2));
        checkOutput("full_nw_count", 204'(nw_count), 204'(4));
        checkOutput("full_nw_drop",  204'(nw_drop),  204'(2));
        exp_ow.push_back(simpleRec(64'h8, 1'b0));
        exp_ow.push_back(simpleRec(64'hC, 1'b0));
        exp_ow.push_back(simpleRec(64'h10, 1'b0));
        exp_ow.push_back(simpleRec(64'h14, 1'b0));
        exp_nw.push_back(simpleRec(64'h0, 1'b0));
        exp_nw.push_back(simpleRec(64'h4, 1'b0));
        exp_nw.push_back(simpleRec(64'h8, 1'b0));
        exp_nw.push_back(simpleRec(64'hC, 1'b0));
        drainAll("full");

        pulseClear();
        checkOutput("clr_ow_drop", 204'(ow_drop), 204'(0));
        checkOutput("clr_nw_drop", 204'(nw_drop), 204'(0));

        // Full ring with a write and a pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            pushBoth(simpleRec(64'h40 + 64'(i * 4), 1'b0));
            writeInstr(64'h40 + 64'(i * 4), 1'b0);
        end
        pushBoth(simpleRec(64'h100, 1'b0));
        checkOutput("wp_ow_count_pre", 204'(ow_count), 204'(4));
        rd_ready = 1'b1;
        writeInstr(64'h100, 1'b0);
        rd_ready = 1'b0;
        checkOutput("wp_ow_count", 204'(ow_count), 204'(4));
        checkOutput("wp_nw_count", 204'(nw_count), 204'(4));
        checkOutput("wp_ow_drop",  204'(ow_drop),  204'(0));
        checkOutput("wp_nw_drop",  204'(nw_drop),  204'(0));
        drainAll("wp");

        // WFI freeze: the WFI plus two followers are kept
        pushBoth(simpleRec(64'h200, 1'b1));
        pushBoth(simpleRec(64'h204, 1'b0));
        pushBoth(simpleRec(64'h208, 1'b0));
        writeInstr(64'h200, 1'b1);
        writeInstr(64'h204, 1'b0);
        checkOutput("wfi_not_yet_frozen", 204'(ow_frozen), 204'(0));
        writeInstr(64'h208, 1'b0);
        checkOutput("wfi_frozen_now", 204'(ow_frozen), 204'(1));
        writeInstr(64'h20C, 1'b0);
        checkOutput("wfi_ow_count", 204'(ow_count), 204'(3));
        checkOutput("wfi_nw_count", 204'(nw_count), 204'(3));
        drainAll("wfi");
        checkOutput("wfi_sticky", 204'(nw_frozen), 204'(1));
        pulseClear();
        checkOutput("wfi_clr_ow_frozen", 204'(ow_frozen), 204'(0));
        checkOutput("wfi_clr_nw_frozen", 204'(nw_frozen), 204'(0));
        checkOutput("wfi_clr_count",     204'(ow_count),  204'(0));

        // Asynchronous reset in the middle of a drain
        pushBoth(simpleRec(64'h300, 1'b0));
        writeInstr(64'h300, 1'b0);
        writeInstr(64'h304, 1'b0);
        rd_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        rd_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkOutput("ow_queue_empty", 204'(exp_ow.size()), 204'(0));
        checkOutput("nw_queue_empty", 204'(exp_nw.size()), 204'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
